memory_arbiter: RTL
===================

MEMORY_ARBITER -- requirements
Module: memory_arbiter

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 4, meaning the maximum number of consecutive port-A grants while port B is requesting.
REQ-002 SHALL have port clock, input, 1, meaning the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1, meaning the asynchronous, active-low reset.
REQ-004 SHALL have port aReq / aWriteEnable, input, 1 / 1, meaning the port-A (core data) request and its write flag.
REQ-005 SHALL have port aAddress / aDataIn, input, 30 / 32, meaning the port-A word address and write data.
REQ-006 SHALL have port aGrant / aReadValid / aDataOut, output, 1 / 1 / 32, meaning the port-A accept strobe, read-return strobe and read data.
REQ-007 SHALL have port bReq / bWriteEnable / bAddress / bDataIn, input, 1 / 1 / 30 / 32, meaning the port-B (loader/DMA) request fields.
REQ-008 SHALL have port bGrant / bReadValid / bDataOut, output, 1 / 1 / 32, meaning the port-B accept strobe, read-return strobe and read data.
REQ-009 SHALL have port backendAddress / backendDataIn / backendWriteEnable, output, 30 / 32 / 1, meaning the drive to the memory backend.
REQ-010 SHALL have port backendDataOut, input, 32, meaning the backend read data, valid one cycle after its address is presented.

Function
REQ-011 SHALL grant at most one port per cycle; aGrant and bGrant are combinational and mutually exclusive.
REQ-012 SHALL grant A when only aReq is high, and grant B when only bReq is high.
REQ-013 SHALL grant A when both request, unless the starvation count equals STARVE_LIMIT, in which case it grants B.
REQ-014 SHALL increment the 3-bit+ starvation count (width = $clog2(STARVE_LIMIT+1)) on each A grant while bReq is high.
REQ-015 SHALL clear the starvation count on any B grant or any cycle with bReq low; the count never exceeds STARVE_LIMIT.
REQ-016 SHALL, in a granted cycle, drive the winner's address, data and write flag to the backend combinationally.
REQ-017 SHALL, with no grant, drive backendWriteEnable=0, backendAddress=0 and backendDataIn=0.
REQ-018 SHALL treat a granted request as accepted in that cycle; the requester may change or drop its fields on the next cycle.
REQ-019 SHALL complete writes on grant; writes produce no ReadValid pulse.
REQ-020 SHALL register the owner of a granted read (states NONE/A/B) and, in the next cycle, pulse that port's ReadValid for exactly one cycle with DataOut=backendDataOut.
REQ-021 SHALL sustain back-to-back reads at one per cycle with 1-cycle latency, including alternating owners.
REQ-022 SHALL drive aDataOut and bDataOut from backendDataOut at all times; the data is meaningful only when the matching ReadValid is high.
REQ-023 SHALL allow a new grant in the same cycle a previous read's ReadValid is asserted.

Reset
REQ-024 SHALL, while reset is low, force the read owner to NONE, the starvation count to 0, and aReadValid=bReadValid=0, asynchronously.
REQ-025 SHALL suppress aGrant, bGrant and backendWriteEnable while reset is low, even when requests are present.
REQ-026 SHALL discard a read in flight when reset is asserted; no ReadValid follows reset release.
REQ-027 SHALL allow arbitration to resume on the first clock edge after reset deasserts.

Structure
REQ-028 SHALL place the read-owner enum (NONE, A, B) and the address/data width constants (30, 32) in a shared package, memory_pkg.
REQ-029 SHALL be one module with no sub-modules; it instantiates between the core and MemoryBackend.

Verification
REQ-030 SHALL cover this scenario: only A reads 0x10 while the backend returns 0xDEADBEEF -> aGrant in cycle 0, aReadValid=1 and aDataOut=0xDEADBEEF in cycle 1, with bReadValid=0.
REQ-031 SHALL cover this scenario: A and B request continuously with STARVE_LIMIT=4 -> the grant pattern is A,A,A,A,B repeating.
REQ-032 SHALL cover this scenario: B writes 0x55 to address 3 while A is idle -> bGrant=1, backendWriteEnable=1, backendAddress=3 and backendDataIn=0x55 in the same cycle, with no ReadValid after.
REQ-033 SHALL cover this scenario: alternating reads A@1, B@2, A@3 in consecutive cycles -> ReadValid pulses A, B, A in the following cycles with the matching backend data.
REQ-034 SHALL cover this scenario: reset is asserted in the cycle after an A read grant -> aReadValid stays 0 and, after release, the first A request is granted with count 0.
REQ-035 SHALL cover this scenario: no requests for 10 cycles -> backendWriteEnable=0, both grants 0 and backendAddress=0.

Source files
------------

// File: rtl/memory_pkg.sv
// Shared types and widths for the memory arbiter and its bus interface.
package memory_pkg;

  localparam int unsigned AddrWidth = 30;
  localparam int unsigned DataWidth = 32;

  // Which port, if any, owns the read whose data the backend returns this cycle.
  typedef enum logic [1:0] {
    OwnerNone = 2'd0,
    OwnerA    = 2'd1,
    OwnerB    = 2'd2
  } readOwner_t;

endpackage

// File: rtl/memory_arbiter_if.sv
// Bus bundle between the two requesters (core data port A, loader/DMA port B),
// the arbiter and the memory backend.
interface memory_arbiter_if;
  import memory_pkg::*;

  // Port A (core data)
  logic                 aReq;
  logic                 aWriteEnable;
  logic [AddrWidth-1:0] aAddress;
  logic [DataWidth-1:0] aDataIn;
  logic                 aGrant;
  logic                 aReadValid;
  logic [DataWidth-1:0] aDataOut;

  // Port B (loader/DMA)
  logic                 bReq;
  logic                 bWriteEnable;
  logic [AddrWidth-1:0] bAddress;
  logic [DataWidth-1:0] bDataIn;
  logic                 bGrant;
  logic                 bReadValid;
  logic [DataWidth-1:0] bDataOut;

  // Memory backend
  logic [AddrWidth-1:0] backendAddress;
  logic [DataWidth-1:0] backendDataIn;
  logic                 backendWriteEnable;
  logic [DataWidth-1:0] backendDataOut;

  // Arbiter view
  modport slave (
    input  aReq, aWriteEnable, aAddress, aDataIn,
    output aGrant, aReadValid, aDataOut,
    input  bReq, bWriteEnable, bAddress, bDataIn,
    output bGrant, bReadValid, bDataOut,
    output backendAddress, backendDataIn, backendWriteEnable,
    input  backendDataOut
  );

  // Requester/backend view
  modport master (
    output aReq, aWriteEnable, aAddress, aDataIn,
    input  aGrant, aReadValid, aDataOut,
    output bReq, bWriteEnable, bAddress, bDataIn,
    input  bGrant, bReadValid, bDataOut,
    input  backendAddress, backendDataIn, backendWriteEnable,
    output backendDataOut
  );

endinterface

// File: rtl/memory_arbiter.sv
// Two-port memory arbiter. Port A wins ties until port B has been passed over
// STARVE_LIMIT times in a row. Grants and backend drive are combinational; read
// data returns one cycle after the grant, tagged with the registered owner.
module memory_arbiter
  import memory_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 4  // must be >= 1
) (
  input logic              clock,
  input logic              reset,  // asynchronous, active low
  memory_arbiter_if.slave  bus
);

  localparam int unsigned CountWidth = $clog2(STARVE_LIMIT + 1);

  logic [CountWidth-1:0] starveCountQ, starveCountD;
  readOwner_t            ownerQ, ownerD;
  logic                  grantA, grantB;
  logic                  starved;

  assign starved = (starveCountQ == CountWidth'(STARVE_LIMIT));

  // Arbitration: A has priority unless B has waited long enough; nothing while in reset.
  always_comb begin
    grantA = 1'b0;
    grantB = 1'b0;
    if (reset) begin
      if (bus.bReq && (!bus.aReq || starved)) begin
        grantB = 1'b1;
      end else if (bus.aReq) begin
        grantA = 1'b1;
      end
    end
  end

  assign bus.aGrant = grantA;
  assign bus.bGrant = grantB;

  // Steer the winner's request to the backend; idle bus is all zeros.
  always_comb begin
    bus.backendAddress     = '0;
    bus.backendDataIn      = '0;
    bus.backendWriteEnable = 1'b0;
    if (grantA) begin
      bus.backendAddress     = bus.aAddress;
      bus.backendDataIn      = bus.aDataIn;
      bus.backendWriteEnable = bus.aWriteEnable;
    end else if (grantB) begin
      bus.backendAddress     = bus.bAddress;
      bus.backendDataIn      = bus.bDataIn;
      bus.backendWriteEnable = bus.bWriteEnable;
    end
  end

  // Count consecutive A wins while B waits; any B win or idle B restarts it.
  always_comb begin
    starveCountD = '0;
    if (bus.bReq && grantA && !starved) begin
      starveCountD = starveCountQ + CountWidth'(1);
    end
  end

  // Next read owner: only a granted read produces a return next cycle.
  always_comb begin
    ownerD = OwnerNone;
    if (grantA && !bus.aWriteEnable) begin
      ownerD = OwnerA;
    end else if (grantB && !bus.bWriteEnable) begin
      ownerD = OwnerB;
    end
  end

  // State registers; reset drops any read in flight.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      starveCountQ <= '0;
      ownerQ       <= OwnerNone;
    end else begin
      starveCountQ <= starveCountD;
      ownerQ       <= ownerD;
    end
  end

  // Read return: backend data is broadcast, the owner's strobe qualifies it.
  always_comb begin
    bus.aReadValid = (ownerQ == OwnerA);
    bus.bReadValid = (ownerQ == OwnerB);
    bus.aDataOut   = bus.backendDataOut;
    bus.bDataOut   = bus.backendDataOut;
  end

endmodule
